// File: rtl/multi_tick_gen.sv
// multi_tick_gen: runtime-programmable multi-channel clock-enable generator (tick strobe + square wave per channel)
// Ports: clk; reset (async, active-high); ch_en per-channel run enable; restart phase-aligns all channels;
//   wr_en/wr_ch/wr_div load a channel's shadow divisor; tick one-cycle strobe every DIV clocks;
//   sq toggles on each tick; pending shadow written but not yet active.
//   MULTI_TICK_CNT_EN adds tick_cnt, one wrapping 16-bit tick counter per channel.
module multi_tick_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 26,
  parameter int DEFAULT_DIV = 20000000,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              restart,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] pending
`ifdef MULTI_TICK_CNT_EN
  ,
  output logic [NUM_CH*16-1:0] tick_cnt
`endif
);
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] act [NUM_CH];
  logic [CNT_W-1:0] shd [NUM_CH];
  logic [NUM_CH-1:0] hit, zero, term, prom;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hit[i]  = wr_en && wr_ch == CH_W'(i);
    assign zero[i] = act[i] == '0;
    // zero is excluded here, so act-1 never wraps into a bogus terminal count
    assign term[i] = ch_en[i] && !zero[i] && cnt[i] == act[i] - CNT_W'(1);
    // promote only at a period boundary or while the channel is not counting, so no runt period
    assign prom[i] = pending[i] && (term[i] || !ch_en[i] || zero[i] || restart);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k] <= '0;
        act[k] <= CNT_W'(DEFAULT_DIV);
        shd[k] <= CNT_W'(DEFAULT_DIV);
      end
      tick <= '0;
      sq <= '0;
      pending <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k] <= restart || (ch_en[k] && (zero[k] || term[k])) ? '0 : ch_en[k] ? cnt[k] + CNT_W'(1) : cnt[k];
        // a write coinciding with restart takes effect immediately, leaving nothing pending
        act[k] <= restart && hit[k] ? wr_div : prom[k] ? shd[k] : act[k];
        shd[k] <= hit[k] ? wr_div : shd[k];
        tick[k] <= !restart && term[k];
        sq[k] <= restart ? 1'b0 : term[k] ? ~sq[k] : sq[k];
        pending[k] <= !restart && (hit[k] || (pending[k] && !prom[k]));
      end
    end
`ifdef MULTI_TICK_CNT_EN
  logic [15:0] tc [NUM_CH];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_tc
    assign tick_cnt[16*i +: 16] = tc[i];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) tc[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) tc[k] <= restart ? 16'd0 : term[k] ? tc[k] + 16'd1 : tc[k];
    end
`endif
endmodule
